// File: rtl/mux_n_rr_pkg.sv
// Shared types and helpers for the N-channel streaming mux.
// Holds the arbitration mode encoding and the index-width helper.
package mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  // Index width that stays at least one bit even for degenerate channel counts.
  function automatic int clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/mux_n_rr_if.sv
// Stream bundle between NCH producers, the mux and one consumer.
// slave = mux side, master = producer/consumer side.
interface mux_n_rr_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int CH_W = clog2_min1(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [CH_W-1:0]      out_ch;
  logic                 out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/mux_n_rr_arbiter.sv
// Round-robin arbiter: first request at or above ptr, wrapping; combinational.
// Search runs over a doubled request vector so the wrap needs no second pass.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int CH_W = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] gnt_idx
);

  logic [2*NCH-1:0] w_req_dbl;
  logic [2*NCH-1:0] w_masked;

  always_comb begin
    logic found;
    w_req_dbl = {req, req};
    w_masked  = '0;
    gnt       = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    for (int j = 0; j < 2*NCH; j++) begin
      w_masked[j] = w_req_dbl[j] & (j >= int'(ptr));
    end
    if (en) begin
      for (int j = 0; j < 2*NCH; j++) begin
        if (!found && w_masked[j]) begin
          found            = 1'b1;
          gnt[j % NCH]     = 1'b1;
          gnt_idx          = CH_W'(j % NCH);
        end
      end
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// NCH-to-1 valid/ready stream mux, select-directed or round-robin, one output register.
// Latency 1 cycle; a stalled full output register drops every in_ready, so nothing is overwritten.
module mux_n_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int CH_W  = clog2_min1(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode_rr,
  input  logic [CH_W-1:0] sel,
  mux_n_rr_if.slave       bus
);

  mux_mode_e         w_mode;
  logic              w_load_en;
  logic              w_xfer;
  logic [NCH-1:0]    w_sel_gnt;
  logic [NCH-1:0]    w_rr_gnt;
  logic [NCH-1:0]    w_gnt;
  logic [CH_W-1:0]   w_rr_idx;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0]  w_gnt_dat;

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_ptr;

  assign w_mode    = mux_mode_e'(mode_rr);
  assign w_load_en = ~r_out_valid | bus.out_ready;

  // An out-of-range sel matches no channel, so it simply grants nothing.
  always_comb begin
    w_sel_gnt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sel_gnt[i] = (sel == CH_W'(i)) & bus.in_valid[i];
    end
  end

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (r_ptr),
    .en      (w_mode == MODE_RR),
    .gnt     (w_rr_gnt),
    .gnt_idx (w_rr_idx)
  );

  always_comb begin
    w_gnt     = (w_mode == MODE_RR) ? w_rr_gnt : w_sel_gnt;
    w_gnt_idx = (w_mode == MODE_RR) ? w_rr_idx : sel;
    w_gnt_dat = '0;
    for (int i = 0; i < NCH; i++) begin
      w_gnt_dat = w_gnt_dat | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
    end
  end

  assign bus.in_ready = w_gnt & {NCH{w_load_en & rst_n}};
  assign w_xfer       = |bus.in_ready;
  assign w_ptr_nxt    = (w_rr_idx == CH_W'(NCH-1)) ? '0 : w_rr_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_dat;
        r_out_ch    <= w_gnt_idx;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Pointer only moves on round-robin grants so select mode leaves it parked.
      if (w_xfer && (w_mode == MODE_RR)) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;

endmodule
